// File: rtl/axis_packet_fifo_if.sv
// Stream FIFO bus: upstream write port, downstream FWFT read port and status.
// A word moves on a rising edge where valid and ready are both 1; ready never depends on valid.
interface axis_packet_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] S_TData;
    logic             S_TValid;
    logic             S_TLast;
    logic             S_TReady;

    logic [WIDTH-1:0] M_TData;
    logic             M_TValid;
    logic             M_TLast;
    logic             M_TReady;

    logic [CW-1:0]    Count;
    logic [CW-1:0]    PktCount;
    logic             isEmpty;
    logic             isFull;
    logic             AlmostFull;
    logic             AlmostEmpty;
    logic [1:0]       State;

    modport slave (
        input  S_TData, S_TValid, S_TLast, M_TReady,
        output S_TReady, M_TData, M_TValid, M_TLast,
        output Count, PktCount, isEmpty, isFull, AlmostFull, AlmostEmpty, State
    );

    modport master (
        output S_TData, S_TValid, S_TLast, M_TReady,
        input  S_TReady, M_TData, M_TValid, M_TLast,
        input  Count, PktCount, isEmpty, isFull, AlmostFull, AlmostEmpty, State
    );
endinterface

// File: rtl/axis_packet_fifo.sv
// First-word-fall-through stream FIFO with optional packet-gated output.
// State is exported on bus.State (0=WAIT, 1=SEND, 2=OVERSIZE).
module axis_packet_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0,
    parameter int AF_LEVEL    = DEPTH - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    axis_packet_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_WAIT     = 2'd0,
        ST_SEND     = 2'd1,
        ST_OVERSIZE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [WIDTH:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic [CW-1:0]  pkt_count, pkt_nxt;
    logic           rdy_en;
    logic           wr_en, rd_en;
    logic           head_last;
    logic           m_valid;
    logic           is_empty, is_full;

    assign is_empty  = (count == '0);
    assign is_full   = (count == CW'(DEPTH));
    assign head_last = mem[rd_ptr][WIDTH];

    // rdy_en keeps S_TReady low until the first edge after Reset releases.
    assign bus.S_TReady = rdy_en && !is_full && !Reset;
    assign m_valid      = (state != ST_WAIT) && !is_empty;
    assign wr_en        = bus.S_TValid && bus.S_TReady;
    assign rd_en        = m_valid && bus.M_TReady;

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        pkt_nxt = pkt_count;
        case ({wr_en && bus.S_TLast, rd_en && head_last})
            2'b10:   pkt_nxt = pkt_count + CW'(1);
            2'b01:   pkt_nxt = pkt_count - CW'(1);
            default: pkt_nxt = pkt_count;
        endcase
    end

    // WAIT looks at the post-edge counts so a packet completed on this edge
    // is offered on the very next cycle, matching the streaming latency.
    always_comb begin
        state_nxt = state;
        if (PACKET_MODE == 0) begin
            state_nxt = ST_SEND;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (pkt_nxt != '0)
                        state_nxt = ST_SEND;
                    else if (count_nxt == CW'(DEPTH))
                        state_nxt = ST_OVERSIZE;
                end
                ST_SEND: begin
                    if (rd_en && head_last && pkt_nxt == '0)
                        state_nxt = ST_WAIT;
                end
                ST_OVERSIZE: begin
                    if (rd_en && head_last)
                        state_nxt = (pkt_nxt == '0) ? ST_WAIT : ST_SEND;
                end
                default: state_nxt = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
            rdy_en    <= 1'b0;
            state     <= (PACKET_MODE != 0) ? ST_WAIT : ST_SEND;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt;
            pkt_count <= pkt_nxt;
            rdy_en    <= 1'b1;
            state     <= state_nxt;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= {bus.S_TLast, bus.S_TData};
    end

    assign bus.M_TData     = mem[rd_ptr][WIDTH-1:0];
    assign bus.M_TLast     = head_last;
    assign bus.M_TValid    = m_valid;
    assign bus.Count       = count;
    assign bus.PktCount    = pkt_count;
    assign bus.isEmpty     = is_empty;
    assign bus.isFull      = is_full;
    assign bus.AlmostFull  = (count >= CW'(AF_LEVEL));
    assign bus.AlmostEmpty = (count <= CW'(AE_LEVEL));
    assign bus.State       = state;
endmodule

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 Parameter WIDTH, 8, bit width of TData.
REQ-002 Parameter DEPTH, 16, number of entries; power of two, at least 4.
REQ-003 Parameter PACKET_MODE, 0, 0 = word streaming, 1 = hold output until a complete packet (TLast word) is stored.
REQ-004 Parameter AF_LEVEL, DEPTH-2, AlmostFull threshold in entries.
REQ-005 Parameter AE_LEVEL, 2, AlmostEmpty threshold in entries.
REQ-006 CLK  input  1  single clock; all state changes on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 S_TData  input  WIDTH  write data.
REQ-009 S_TValid  input  1  upstream data valid.
REQ-010 S_TLast  input  1  last word of packet.
REQ-011 S_TReady  output  1  FIFO can accept a word.
REQ-012 M_TData  output  WIDTH  head-of-FIFO data.
REQ-013 M_TValid  output  1  head word is available.
REQ-014 M_TLast  output  1  TLast flag stored with the head word.
REQ-015 M_TReady  input  1  downstream ready.
REQ-016 Count  output  $clog2(DEPTH)+1  stored word count, 0..DEPTH.
REQ-017 PktCount  output  $clog2(DEPTH)+1  stored complete packets, i.e. stored words with TLast=1.
REQ-018 isEmpty, isFull, AlmostFull, AlmostEmpty  output  1 each  status flags.

Function
REQ-019 A write occurs on a rising edge where S_TValid=1 and S_TReady=1. The word stores {S_TLast, S_TData} at the write pointer.
REQ-020 S_TReady = !isFull && !Reset. It shall not depend on S_TValid.
REQ-021 A read occurs on a rising edge where M_TValid=1 and M_TReady=1. The read pointer advances.
REQ-022 Output is first-word-fall-through. M_TData and M_TLast show the head entry combinationally. A word written into an empty FIFO is visible with M_TValid=1 on the next cycle (1-cycle latency).
REQ-023 M_TData and M_TLast shall be held stable while M_TValid=1 and M_TReady=0.
REQ-024 Pointers shall be $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
REQ-025 Count rules: write only -> +1; read only -> -1; write and read in the same cycle -> unchanged.
REQ-026 When full, writes are refused even if a read occurs in the same cycle. A write into a word slot freed by that cycle's read is not permitted.
REQ-027 When empty, M_TValid=0 and there is no bypass from S_TData to M_TData.
REQ-028 isEmpty = (Count==0); isFull = (Count==DEPTH); AlmostFull = (Count>=AF_LEVEL); AlmostEmpty = (Count<=AE_LEVEL).
REQ-029 PktCount increments on a write with S_TLast=1 and decrements on a read with M_TLast=1; if both happen in the same cycle it is unchanged.
REQ-030 With PACKET_MODE=0, M_TValid = !isEmpty.
REQ-031 With PACKET_MODE=1, a read-gating state machine with states WAIT, SEND and OVERSIZE controls M_TValid:
- WAIT: M_TValid=0. Go to SEND when PktCount>0. Go to OVERSIZE when isFull and PktCount==0.
- SEND: M_TValid = !isEmpty. Return to WAIT after a read of an M_TLast=1 word if PktCount would then be 0; otherwise stay in SEND.
- OVERSIZE: M_TValid = !isEmpty, draining a packet longer than DEPTH. Go to WAIT after a read of an M_TLast=1 word if PktCount would then be 0, else go to SEND.
REQ-032 With PACKET_MODE=0, the state machine stays in SEND permanently.

Reset
REQ-033 Reset assertion shall take effect immediately, without waiting for a clock edge: pointers, Count and PktCount go to 0, state goes to WAIT (SEND when PACKET_MODE=0), M_TValid=0, S_TReady=0, isEmpty=1, isFull=0, AlmostEmpty=1, AlmostFull=0.
REQ-034 Memory contents are not reset. M_TData and M_TLast are don't-care while M_TValid=0.
REQ-035 Reset asserted mid-packet or mid-transfer discards all stored words. The first write after Reset deasserts lands at entry 0.
REQ-036 S_TReady shall rise on the first rising edge after Reset deasserts.

Verification
REQ-037 WIDTH=8, DEPTH=4, PACKET_MODE=0; write 0x11..0x44 with M_TReady=0 -> isFull=1, S_TReady=0, Count=4; then M_TReady=1 -> reads 0x11,0x22,0x33,0x44 in order, isEmpty=1.
REQ-038 Continuous S_TValid=1 and M_TReady=1 from empty -> after the first cycle, one word per cycle passes through, Count stays 1, data order is preserved.
REQ-039 PACKET_MODE=1; write 3 words with TLast on the 3rd, M_TReady=1 throughout -> M_TValid stays 0 until the cycle after the 3rd write, then 3 reads occur and PktCount returns from 1 to 0.
REQ-040 PACKET_MODE=1, DEPTH=4; write 6 words with no TLast until the 6th -> FIFO fills, enters OVERSIZE, drains all 6 words in order, ends in WAIT with Count=0.
REQ-041 Fill to 2 words, assert Reset between clock edges -> outputs reach reset values before the next edge; after release, writing 0xA5 gives M_TData=0xA5.
REQ-042 Write 7 words (DEPTH=8) with M_TReady=0, then 3 simultaneous read+write cycles -> Count stays 7, pointers wrap, output order is correct, AlmostFull=1 with AF_LEVEL=6.
